// File: rtl/multi_room_light_ctrl.sv
// Per-room lighting controller: occupancy-driven auto lighting with hold timer,
// wall-switch manual override, shared hysteretic darkness flag and global off.
module multi_room_light_ctrl #(
  parameter int unsigned ROOMS    = 4,
  parameter int unsigned LUX_W    = 8,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned LUX_ON   = 16,
  parameter int unsigned LUX_OFF  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LUX_W-1:0]             lux,
  input  logic [ROOMS-1:0]             r_motion_sen,
  input  logic [ROOMS-1:0]             r_ir_sen,
  input  logic [ROOMS-1:0]             manual,
  input  logic                         all_off,
  output logic [ROOMS-1:0]             l_out,
  output logic [$clog2(ROOMS+1)-1:0]   on_count,
  output logic                         dark
);

  localparam int unsigned TW = $clog2(HOLD_CYC);
  localparam int unsigned CW = $clog2(ROOMS + 1);
  localparam logic [TW-1:0]    TimerMax = TW'(HOLD_CYC - 1);
  localparam logic [LUX_W:0]   LuxOnTh  = (LUX_W + 1)'(LUX_ON);
  localparam logic [LUX_W:0]   LuxOffTh = (LUX_W + 1)'(LUX_OFF);

  typedef enum logic [1:0] {
    StOff    = 2'b00,
    StAuto   = 2'b01,
    StManOn  = 2'b10,
    StManOff = 2'b11
  } room_st_e;

  room_st_e         state_q [ROOMS];
  logic [TW-1:0]    timer_q [ROOMS];
  logic [ROOMS-1:0] manual_q;
  logic             dark_q;

  logic [ROOMS-1:0] occ;
  logic [ROOMS-1:0] tgl;
  logic             lux_lo;
  logic             lux_hi;

  assign occ    = r_ir_sen & r_motion_sen;
  assign tgl    = manual & ~manual_q;
  assign lux_lo = ({1'b0, lux} < LuxOnTh);
  assign lux_hi = ({1'b0, lux} >= LuxOffTh);

  always_ff @(posedge clk) begin
    if (!reset) begin
      dark_q   <= 1'b0;
      manual_q <= '0;
      for (int i = 0; i < ROOMS; i++) begin
        state_q[i] <= StOff;
        timer_q[i] <= '0;
      end
    end else begin
      manual_q <= manual;
      if (lux_lo) begin
        dark_q <= 1'b1;
      end else if (lux_hi) begin
        dark_q <= 1'b0;
      end
      for (int i = 0; i < ROOMS; i++) begin
        if (all_off) begin
          state_q[i] <= StOff;
          timer_q[i] <= '0;
        end else begin
          case (state_q[i])
            StOff: begin
              // Old dark_q is used, so a lamp never reacts to the flag it is being set on.
              if (tgl[i]) begin
                state_q[i] <= StManOn;
              end else if (occ[i] && dark_q) begin
                state_q[i] <= StAuto;
                timer_q[i] <= TimerMax;
              end
            end
            StAuto: begin
              if (tgl[i]) begin
                state_q[i] <= StManOff;
                timer_q[i] <= TimerMax;
              end else if (occ[i]) begin
                timer_q[i] <= TimerMax;
              end else if (timer_q[i] == '0) begin
                state_q[i] <= StOff;
              end else begin
                timer_q[i] <= timer_q[i] - 1'b1;
              end
            end
            StManOn: begin
              if (tgl[i]) begin
                state_q[i] <= StManOff;
                timer_q[i] <= TimerMax;
              end
            end
            StManOff: begin
              // Vacancy for the full hold time hands the room back to automatic mode.
              if (tgl[i]) begin
                state_q[i] <= StManOn;
              end else if (occ[i]) begin
                timer_q[i] <= TimerMax;
              end else if (timer_q[i] == '0) begin
                state_q[i] <= StOff;
              end else begin
                timer_q[i] <= timer_q[i] - 1'b1;
              end
            end
            default: begin
              state_q[i] <= StOff;
              timer_q[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    l_out    = '0;
    on_count = '0;
    for (int i = 0; i < ROOMS; i++) begin
      l_out[i] = (state_q[i] == StAuto) || (state_q[i] == StManOn);
      on_count = on_count + CW'(l_out[i]);
    end
  end

  assign dark = dark_q;

endmodule

// File: tb/tb_multi_room_light_ctrl.sv
// Bench for multi_room_light_ctrl: directed vector table, hand sequences for
// override/all-off/reset corners, then random traffic against a deadline-based model.
module tb_multi_room_light_ctrl;

  localparam int unsigned ROOMS = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned LON   = 16;
  localparam int unsigned LOFF  = 32;

  localparam int KIdle = 0, KAuto = 1, KForcedOn = 2, KForcedOff = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lux;
  logic [3:0] mo, ir, mn;
  logic       ao;
  logic [3:0] l_out;
  logic [2:0] on_count;
  logic       dark;

  always #5 clk = ~clk;

  multi_room_light_ctrl #(
    .ROOMS   (ROOMS),
    .LUX_W   (8),
    .HOLD_CYC(HOLD),
    .LUX_ON  (LON),
    .LUX_OFF (LOFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lux         (lux),
    .r_motion_sen(mo),
    .r_ir_sen    (ir),
    .manual      (mn),
    .all_off     (ao),
    .l_out       (l_out),
    .on_count    (on_count),
    .dark        (dark)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: each room has a mode and an absolute edge number at which the hold expires.
  int         m_kind [ROOMS];
  int         m_dl   [ROOMS];
  int         edge_n = 0;
  bit         m_dark = 1'b0;
  logic [3:0] m_prev = '0;

  task automatic model_step();
    logic [3:0] occ_v, tgl_v;
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < ROOMS; i++) m_kind[i] = KIdle;
      m_prev = '0;
      m_dark = 1'b0;
      return;
    end
    occ_v  = ir & mo;
    tgl_v  = mn & ~m_prev;
    m_prev = mn;
    for (int i = 0; i < ROOMS; i++) begin
      if (ao) begin
        m_kind[i] = KIdle;
      end else if (m_kind[i] == KIdle) begin
        if (tgl_v[i]) m_kind[i] = KForcedOn;
        else if (occ_v[i] && m_dark) begin
          m_kind[i] = KAuto;
          m_dl[i]   = edge_n + HOLD;
        end
      end else if (m_kind[i] == KForcedOn) begin
        if (tgl_v[i]) begin
          m_kind[i] = KForcedOff;
          m_dl[i]   = edge_n + HOLD;
        end
      end else if (tgl_v[i]) begin
        m_kind[i] = (m_kind[i] == KAuto) ? KForcedOff : KForcedOn;
        m_dl[i]   = edge_n + HOLD;
      end else if (occ_v[i]) begin
        m_dl[i] = edge_n + HOLD;
      end else if (edge_n >= m_dl[i]) begin
        m_kind[i] = KIdle;
      end
    end
    if (lux < LON) m_dark = 1'b1;
    else if (lux >= LOFF) m_dark = 1'b0;
  endtask

  function automatic logic [3:0] m_lamps();
    logic [3:0] r;
    for (int i = 0; i < ROOMS; i++) r[i] = (m_kind[i] == KAuto) || (m_kind[i] == KForcedOn);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic r, logic [7:0] lx, logic [3:0] m, logic [3:0] s,
                       logic [3:0] n, logic a);
    reset = r; lux = lx; mo = m; ir = s; mn = n; ao = a;
  endtask

  task automatic step_chk(string nm, logic [3:0] e);
    tick();
    chk({nm, "_l_out"}, 32'(l_out), 32'(e));
    chk({nm, "_on_count"}, 32'(on_count), 32'($countones(e)));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] lx;
    logic [3:0] mo;
    logic [3:0] ir;
    logic [3:0] mn;
    logic       ao;
    logic [3:0] el;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // reset held with every input high
    vecs.push_back('{1'b0, 8'hFF, 4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0});
    // go dark, then one occupancy pulse in room 0: lit for exactly HOLD edges
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
    vecs.push_back('{1'b1, 8'd8,  4'h1, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
    // motion without IR is not occupancy
    vecs.push_back('{1'b1, 8'd8,  4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
    // hysteresis: light, then band value holds not-dark, dip dark, band holds dark
    vecs.push_back('{1'b1, 8'd40, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 8'd20, 4'h2, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 8'd8,  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});
    vecs.push_back('{1'b1, 8'd20, 4'h2, 4'h2, 4'h0, 1'b0, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 8'd20, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 8'd20, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 8'd20, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 8'd20, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1});

    for (int i = 0; i < ROOMS; i++) begin
      m_kind[i] = KIdle;
      m_dl[i]   = 0;
    end
    drive(vecs[0].rst, vecs[0].lx, vecs[0].mo, vecs[0].ir, vecs[0].mn, vecs[0].ao);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].lx, vecs[k].mo, vecs[k].ir, vecs[k].mn, vecs[k].ao);
      tick();
      chk($sformatf("vec%0d_l_out", k), 32'(l_out), 32'(vecs[k].el));
      chk($sformatf("vec%0d_on_count", k), 32'(on_count), 32'($countones(vecs[k].el)));
      chk($sformatf("vec%0d_dark", k), 32'(dark), 32'(vecs[k].ed));
    end

    // Manual override of an auto room, then return to auto after vacancy
    drive(1, 8'd8, 4'h4, 4'h4, 4'h0, 0); step_chk("ovr_auto", 4'h4);
    drive(1, 8'd8, 4'h4, 4'h4, 4'h4, 0); step_chk("ovr_manoff", 4'h0);
    drive(1, 8'd8, 4'h4, 4'h4, 4'h4, 0); step_chk("ovr_held", 4'h0);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 0);
    for (int k = 0; k < 4; k++) step_chk($sformatf("ovr_vac%0d", k), 4'h0);
    drive(1, 8'd8, 4'h4, 4'h4, 4'h0, 0); step_chk("ovr_reauto", 4'h4);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 1); step_chk("ovr_alloff", 4'h0);

    // all_off wins over a same-cycle toggle; held switch does not retoggle
    drive(1, 8'd8, 4'h0, 4'h0, 4'h9, 0); step_chk("sim_manon", 4'h9);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 0); step_chk("sim_keep", 4'h9);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h2, 1); step_chk("sim_alloff", 4'h0);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h2, 0); step_chk("sim_held0", 4'h0);
    step_chk("sim_held1", 4'h0);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 0); step_chk("sim_rel", 4'h0);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h2, 0); step_chk("sim_newtgl", 4'h2);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 1); step_chk("sim_clear", 4'h0);

    // Reset mid-operation clears lamps and dark; relight needs dark again
    drive(1, 8'd8, 4'h0, 4'h0, 4'hF, 0); step_chk("rst_all_on", 4'hF);
    drive(1, 8'd8, 4'h0, 4'h0, 4'h0, 0); step_chk("rst_keep", 4'hF);
    drive(0, 8'd8, 4'hF, 4'hF, 4'h0, 0); step_chk("rst_mid", 4'h0);
    chk("rst_mid_dark", 32'(dark), 32'd0);
    drive(1, 8'd20, 4'hF, 4'hF, 4'h0, 0); step_chk("rst_band", 4'h0);
    chk("rst_band_dark", 32'(dark), 32'd0);
    drive(1, 8'd8, 4'hF, 4'hF, 4'h0, 0); step_chk("rst_darkedge", 4'h0);
    chk("rst_darkedge_dark", 32'(dark), 32'd1);
    step_chk("rst_relight", 4'hF);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] nmn;
      logic       r;
      r   = ($urandom_range(0, 63) != 0);
      nmn = mn;
      for (int b = 0; b < ROOMS; b++) if ($urandom_range(0, 7) == 0) nmn[b] = ~nmn[b];
      if (!r) nmn = '0;
      drive(r, 8'($urandom_range(0, 47)), 4'($urandom), 4'($urandom & $urandom), nmn,
            ($urandom_range(0, 31) == 0));
      tick();
      chk("rnd_l_out", 32'(l_out), 32'(m_lamps()));
      chk("rnd_on_count", 32'(on_count), 32'($countones(m_lamps())));
      chk("rnd_dark", 32'(dark), 32'(m_dark));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
